tcp_ack_tracker: RTL and testbench

- Multi-flow, pipelined successor to the per-packet ACK evaluator in tcp_slow.
- Holds per-flow ACK state (last accepted ACK number, duplicate-ACK count) in an internal table.
- Evaluates incoming ACKs with wrap-safe modular sequence arithmetic, then writes back the updated state.
- Returns per-ACK results (new ACK, dup, retransmit trigger, bytes acked, TX head pointer) over a valid/ready handshake to the TX/retransmit logic.

---
 rtl/tcp_ack_tracker.sv | 171 +++++++++++++++++
 tb/tb_tcp_ack_tracker.sv | 354 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/tcp_ack_tracker.sv
// Multi-flow TCP ACK tracker: per-flow ACK state table with a 2-stage evaluate/write-back pipeline.
// Optional macro ACK_TRACK_STATS_EN adds per-class evaluation counters.
module tcp_ack_tracker #(
    parameter int NUM_FLOWS        = 64,
    parameter int SEQ_W            = 32,
    parameter int TX_PTR_W         = 16,
    parameter int RT_ACK_THRESHOLD = 3,
    localparam int FLOWID_W        = $clog2(NUM_FLOWS),
    localparam int CNT_W           = $clog2(RT_ACK_THRESHOLD + 1)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  init_val,
    input  logic [FLOWID_W-1:0]   init_flowid,
    input  logic [SEQ_W-1:0]      init_ack_num,
    output logic                  init_rdy,
    input  logic                  req_val,
    input  logic [FLOWID_W-1:0]   req_flowid,
    input  logic [SEQ_W-1:0]      req_ack_num,
    input  logic [SEQ_W-1:0]      req_seq_num,
    output logic                  req_rdy,
    output logic                  resp_val,
    output logic [FLOWID_W-1:0]   resp_flowid,
    output logic [SEQ_W-1:0]      resp_ack_num,
    output logic [TX_PTR_W:0]     resp_tx_head_ptr,
    output logic                  resp_new_ack,
    output logic                  resp_dup,
    output logic                  resp_rt,
    output logic [SEQ_W-1:0]      resp_acked_bytes,
    input  logic                  resp_rdy
`ifdef ACK_TRACK_STATS_EN
    ,
    output logic [31:0]           stat_new_ack,
    output logic [31:0]           stat_dup_ack,
    output logic [31:0]           stat_rt,
    output logic [31:0]           stat_stale
`endif
);

    localparam logic [CNT_W:0] RT_THRESH_C = (CNT_W + 1)'(RT_ACK_THRESHOLD);

    // Handshakes: a transfer happens on a cycle where both val and rdy are high;
    // a producer holding val keeps its payload stable until that cycle.

    logic [SEQ_W-1:0] ack_tbl [NUM_FLOWS];
    logic [CNT_W-1:0] cnt_tbl [NUM_FLOWS];

    logic                s1_valid;
    logic [FLOWID_W-1:0] s1_flowid;
    logic [SEQ_W-1:0]    s1_ack;
    logic [SEQ_W-1:0]    s1_seq;
    logic [SEQ_W-1:0]    s1_cur;
    logic [CNT_W-1:0]    s1_cnt;

    logic                s1_adv;
    logic                init_fire;
    logic                req_fire;
    logic [SEQ_W-1:0]    rd_ack;
    logic [CNT_W-1:0]    rd_cnt;

    logic [SEQ_W-1:0]    outstanding;
    logic [SEQ_W-1:0]    diff;
    logic [CNT_W:0]      cnt_inc;
    logic                ev_new;
    logic                ev_dup;
    logic                ev_rt;
    logic [SEQ_W-1:0]    nxt_ack;
    logic [CNT_W-1:0]    nxt_cnt;
    logic [SEQ_W-1:0]    nxt_bytes;

    assign s1_adv    = s1_valid & (~resp_val | resp_rdy);
    assign init_rdy  = ~s1_valid;
    assign req_rdy   = ~init_val & (~s1_valid | s1_adv);
    assign init_fire = init_val & init_rdy;
    assign req_fire  = req_val & req_rdy;

    // Write-first read: a same-cycle write-back to the requested flow wins over the table.
    always_comb begin
        rd_ack = ack_tbl[req_flowid];
        rd_cnt = cnt_tbl[req_flowid];
        if (s1_adv && (s1_flowid == req_flowid)) begin
            rd_ack = nxt_ack;
            rd_cnt = nxt_cnt;
        end
    end

    // Sequence comparisons use modular differences only, so wrap past zero is transparent.
    always_comb begin
        outstanding = s1_seq - s1_cur;
        diff        = s1_ack - s1_cur;
        cnt_inc     = {1'b0, s1_cnt} + {{CNT_W{1'b0}}, 1'b1};
        ev_new      = (outstanding != '0) && (diff != '0) && (diff <= outstanding);
        ev_dup      = (outstanding != '0) && (diff == '0);
        ev_rt       = ev_dup && (cnt_inc == RT_THRESH_C);
        nxt_ack     = ev_new ? s1_ack : s1_cur;
        nxt_cnt     = (ev_dup && !ev_rt) ? cnt_inc[CNT_W-1:0] : '0;
        nxt_bytes   = ev_new ? diff : '0;
    end

    // Init and stage1 write-back never coincide because init_rdy requires an empty stage1.
    always_ff @(posedge clk) begin
        if (init_fire) begin
            ack_tbl[init_flowid] <= init_ack_num;
            cnt_tbl[init_flowid] <= '0;
        end else if (s1_adv) begin
            ack_tbl[s1_flowid] <= nxt_ack;
            cnt_tbl[s1_flowid] <= nxt_cnt;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1_valid  <= 1'b0;
            s1_flowid <= '0;
            s1_ack    <= '0;
            s1_seq    <= '0;
            s1_cur    <= '0;
            s1_cnt    <= '0;
        end else if (req_fire) begin
            s1_valid  <= 1'b1;
            s1_flowid <= req_flowid;
            s1_ack    <= req_ack_num;
            s1_seq    <= req_seq_num;
            s1_cur    <= rd_ack;
            s1_cnt    <= rd_cnt;
        end else if (s1_adv) begin
            s1_valid  <= 1'b0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            resp_val         <= 1'b0;
            resp_flowid      <= '0;
            resp_ack_num     <= '0;
            resp_new_ack     <= 1'b0;
            resp_dup         <= 1'b0;
            resp_rt          <= 1'b0;
            resp_acked_bytes <= '0;
        end else if (s1_adv) begin
            resp_val         <= 1'b1;
            resp_flowid      <= s1_flowid;
            resp_ack_num     <= nxt_ack;
            resp_new_ack     <= ev_new;
            resp_dup         <= ev_dup;
            resp_rt          <= ev_rt;
            resp_acked_bytes <= nxt_bytes;
        end else if (resp_rdy) begin
            resp_val         <= 1'b0;
        end
    end

    assign resp_tx_head_ptr = resp_ack_num[TX_PTR_W:0];

`ifdef ACK_TRACK_STATS_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stat_new_ack <= '0;
            stat_dup_ack <= '0;
            stat_rt      <= '0;
            stat_stale   <= '0;
        end else if (s1_adv) begin
            if (ev_new) stat_new_ack <= stat_new_ack + 32'd1;
            if (ev_dup) stat_dup_ack <= stat_dup_ack + 32'd1;
            if (ev_rt) stat_rt <= stat_rt + 32'd1;
            if (!ev_new && !ev_dup) stat_stale <= stat_stale + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_tcp_ack_tracker.sv
// Self-checking bench for tcp_ack_tracker: directed scenarios plus randomized traffic,
// checked against an arithmetic per-flow ACK model and a response queue.
module tb_tcp_ack_tracker;

    localparam int NF  = 64;
    localparam int SW  = 32;
    localparam int TPW = 16;
    localparam int FW  = 6;
    localparam int RW  = FW + SW + 3 + SW;

    logic          clk;
    logic          rst;
    logic          init_val;
    logic [FW-1:0] init_flowid;
    logic [SW-1:0] init_ack_num;
    logic          init_rdy;
    logic          req_val;
    logic [FW-1:0] req_flowid;
    logic [SW-1:0] req_ack_num;
    logic [SW-1:0] req_seq_num;
    logic          req_rdy;
    logic          resp_val;
    logic [FW-1:0] resp_flowid;
    logic [SW-1:0] resp_ack_num;
    logic [TPW:0]  resp_tx_head_ptr;
    logic          resp_new_ack;
    logic          resp_dup;
    logic          resp_rt;
    logic [SW-1:0] resp_acked_bytes;
    logic          resp_rdy;
`ifdef ACK_TRACK_STATS_EN
    logic [31:0]   stat_new_ack;
    logic [31:0]   stat_dup_ack;
    logic [31:0]   stat_rt;
    logic [31:0]   stat_stale;
`endif

    tcp_ack_tracker dut (
        .clk(clk), .rst(rst),
        .init_val(init_val), .init_flowid(init_flowid), .init_ack_num(init_ack_num), .init_rdy(init_rdy),
        .req_val(req_val), .req_flowid(req_flowid), .req_ack_num(req_ack_num),
        .req_seq_num(req_seq_num), .req_rdy(req_rdy),
        .resp_val(resp_val), .resp_flowid(resp_flowid), .resp_ack_num(resp_ack_num),
        .resp_tx_head_ptr(resp_tx_head_ptr), .resp_new_ack(resp_new_ack), .resp_dup(resp_dup),
        .resp_rt(resp_rt), .resp_acked_bytes(resp_acked_bytes), .resp_rdy(resp_rdy)
`ifdef ACK_TRACK_STATS_EN
        , .stat_new_ack(stat_new_ack), .stat_dup_ack(stat_dup_ack),
        .stat_rt(stat_rt), .stat_stale(stat_stale)
`endif
    );

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_cmp;
    int n_fail;

    // behavioural model state
    logic [SW-1:0] m_ack [NF];
    int            m_cnt [NF];
    int            sc_new, sc_dup, sc_rt, sc_stale;
    logic [RW-1:0] exp_q [$];
    logic [RW-1:0] got_q [$];
    int            rdy_mode;
    int            pat_i;

    function automatic logic [RW-1:0] pack(input logic [FW-1:0] f, input logic [SW-1:0] a,
                                           input logic n, input logic d, input logic r,
                                           input logic [SW-1:0] b);
        return {f, a, n, d, r, b};
    endfunction

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Model: evaluate one accepted request in acceptance order, from the ACK rules.
    task automatic model_req(input logic [FW-1:0] f, input logic [SW-1:0] a, input logic [SW-1:0] s);
        logic [SW-1:0] outst, d;
        logic n, du, r;
        outst = s - m_ack[f];
        d     = a - m_ack[f];
        n = 0; du = 0; r = 0;
        if (outst != 0 && d != 0 && d <= outst) begin
            n = 1;
            m_ack[f] = a;
            m_cnt[f] = 0;
            sc_new++;
        end else if (outst != 0 && d == 0) begin
            du = 1;
            sc_dup++;
            m_cnt[f] = m_cnt[f] + 1;
            if (m_cnt[f] == 3) begin
                r = 1;
                m_cnt[f] = 0;
                sc_rt++;
            end
        end else begin
            m_cnt[f] = 0;
            sc_stale++;
            d = 0;
        end
        exp_q.push_back(pack(f, m_ack[f], n, du, r, n ? d : '0));
    endtask

    // compare process: observes handshakes mid-cycle
    task automatic monitor_loop();
        logic          prev_stall;
        logic [RW-1:0] held, act, e;
        prev_stall = 0;
        held = '0;
        forever begin
            @(negedge clk);
            if (rst) begin
                prev_stall = 0;
            end else begin
                act = pack(resp_flowid, resp_ack_num, resp_new_ack, resp_dup, resp_rt, resp_acked_bytes);
                if (init_val) check("req_rdy_while_init", req_rdy, 1'b0);
                if (init_val && init_rdy) begin
                    m_ack[init_flowid] = init_ack_num;
                    m_cnt[init_flowid] = 0;
                end
                if (req_val && req_rdy) model_req(req_flowid, req_ack_num, req_seq_num);
                if (prev_stall) check("stall_hold", {resp_val, act}, {1'b1, held});
                if (resp_val && resp_rdy) begin
                    if (exp_q.size() == 0) begin
                        check("resp_unexpected", 1'b1, 1'b0);
                    end else begin
                        e = exp_q.pop_front();
                        check("resp", act, e);
                        check("head_ptr", resp_tx_head_ptr, e[SW+3+SW-1 -: SW] & 32'h1FFFF);
                    end
                    got_q.push_back(act);
                end
                prev_stall = resp_val && !resp_rdy;
                held = act;
            end
        end
    endtask

    task automatic rdy_loop();
        logic [3:0] pat;
        pat = 4'b1001;
        forever begin
            @(posedge clk);
            #1;
            case (rdy_mode)
                1: resp_rdy = 1'($urandom_range(0, 1));
                2: begin resp_rdy = pat[3 - pat_i]; pat_i = (pat_i + 1) % 4; end
                3: resp_rdy = 1'b0;
                default: resp_rdy = 1'b1;
            endcase
        end
    endtask

    // driver tasks: start at posedge+1, return at posedge+1 after acceptance
    task automatic do_init(input logic [FW-1:0] f, input logic [SW-1:0] a);
        bit ok;
        ok = 0;
        init_val = 1; init_flowid = f; init_ack_num = a;
        for (int i = 0; i < 200 && !ok; i++) begin
            @(negedge clk);
            if (init_rdy) ok = 1;
            else begin @(posedge clk); #1; end
        end
        @(posedge clk); #1;
        init_val = 0;
        if (!ok) check("init_timeout", 1'b0, 1'b1);
    endtask

    task automatic do_req(input logic [FW-1:0] f, input logic [SW-1:0] a, input logic [SW-1:0] s);
        bit ok;
        ok = 0;
        req_val = 1; req_flowid = f; req_ack_num = a; req_seq_num = s;
        for (int i = 0; i < 200 && !ok; i++) begin
            @(negedge clk);
            if (req_rdy) ok = 1;
            else begin @(posedge clk); #1; end
        end
        @(posedge clk); #1;
        req_val = 0;
        if (!ok) check("req_timeout", 1'b0, 1'b1);
    endtask

    task automatic drain();
        bit ok;
        ok = 0;
        for (int i = 0; i < 400 && !ok; i++) begin
            @(negedge clk);
            if (exp_q.size() == 0 && !resp_val) ok = 1;
        end
        check("drain", ok, 1'b1);
        @(posedge clk); #1;
    endtask

    task automatic expect_got(input string name, input int idx, input logic [RW-1:0] e);
        if (idx >= got_q.size()) check(name, 1'b0, 1'b1);
        else check(name, got_q[idx], e);
    endtask

    initial begin
        int base;
        logic [FW-1:0] f;
        logic [SW-1:0] cur, a, s;
        n_cmp = 0; n_fail = 0;
        sc_new = 0; sc_dup = 0; sc_rt = 0; sc_stale = 0;
        rdy_mode = 0; pat_i = 0;
        rst = 1; resp_rdy = 1;
        init_val = 0; init_flowid = '0; init_ack_num = '0;
        req_val = 0; req_flowid = '0; req_ack_num = '0; req_seq_num = '0;
        for (int i = 0; i < NF; i++) begin m_ack[i] = '0; m_cnt[i] = 0; end
        fork
            monitor_loop();
            rdy_loop();
            begin
                #2000000;
                $display("FAIL watchdog: simulation did not complete");
                $fatal(1, "watchdog");
            end
        join_none

        // reset state
        repeat (2) @(negedge clk);
        check("rst_resp_val", resp_val, 1'b0);
        check("rst_resp_data", {resp_flowid, resp_ack_num, resp_new_ack, resp_dup, resp_rt, resp_acked_bytes}, '0);
        check("rst_rdys", {init_rdy, req_rdy}, 2'b11);
        @(posedge clk); #1;
        rst = 0;

        // single new ACK with exact latency
        do_init(7, 32'd9999);
        do_init(5, 32'd1000);
        do_req(5, 32'd1500, 32'd2000);
        @(negedge clk);
        check("lat_t1", resp_val, 1'b0);
        @(negedge clk);
        check("lat_t2", resp_val, 1'b1);
        check("t1_head", resp_tx_head_ptr, 17'(1500));
        drain();
        expect_got("t1_new", 0, pack(5, 32'd1500, 1, 0, 0, 32'd500));

        // duplicate ACKs back-to-back, fast retransmit on the third
        base = got_q.size();
        for (int i = 0; i < 4; i++) do_req(5, 32'd1500, 32'd2000);
        drain();
        expect_got("dup1", base + 0, pack(5, 32'd1500, 0, 1, 0, 0));
        expect_got("dup2", base + 1, pack(5, 32'd1500, 0, 1, 0, 0));
        expect_got("dup3_rt", base + 2, pack(5, 32'd1500, 0, 1, 1, 0));
        expect_got("dup4", base + 3, pack(5, 32'd1500, 0, 1, 0, 0));

        // wrap-around
        base = got_q.size();
        do_init(9, 32'hFFFF_FF00);
        do_req(9, 32'h0000_0010, 32'h0000_0100);
        do_req(9, 32'h0000_0200, 32'h0000_0100);
        drain();
        expect_got("wrap_new", base + 0, pack(9, 32'h10, 1, 0, 0, 32'h110));
        expect_got("wrap_stale", base + 1, pack(9, 32'h10, 0, 0, 0, 0));

        // nothing outstanding clears count; init then immediate request
        base = got_q.size();
        do_init(3, 32'd42);
        do_req(3, 32'd42, 32'd50);
        do_req(3, 32'd42, 32'd42);
        for (int i = 0; i < 3; i++) do_req(3, 32'd42, 32'd50);
        do_init(7, 32'd100);
        do_req(7, 32'd150, 32'd200);
        drain();
        expect_got("idle_flags0", base + 1, pack(3, 32'd42, 0, 0, 0, 0));
        expect_got("cnt_cleared", base + 3, pack(3, 32'd42, 0, 1, 0, 0));
        expect_got("cnt_rt", base + 4, pack(3, 32'd42, 0, 1, 1, 0));
        expect_got("init_bypass", base + 5, pack(7, 32'd150, 1, 0, 0, 32'd50));

        // interleaved flows with backpressure pattern 1,0,0,1
        do_init(1, 32'd100);
        do_init(2, 32'd5000);
        base = got_q.size();
        pat_i = 0;
        rdy_mode = 2;
        do_req(1, 32'd150, 32'd300);
        do_req(2, 32'd5100, 32'd6000);
        do_req(1, 32'd200, 32'd300);
        do_req(2, 32'd5100, 32'd6000);
        do_req(1, 32'd200, 32'd300);
        do_req(2, 32'd6000, 32'd6000);
        drain();
        rdy_mode = 0;
        expect_got("il_f1a", base + 0, pack(1, 32'd150, 1, 0, 0, 32'd50));
        expect_got("il_f2a", base + 1, pack(2, 32'd5100, 1, 0, 0, 32'd100));
        expect_got("il_f1b", base + 2, pack(1, 32'd200, 1, 0, 0, 32'd50));
        expect_got("il_f2b", base + 3, pack(2, 32'd5100, 0, 1, 0, 0));
        expect_got("il_f2c", base + 5, pack(2, 32'd6000, 1, 0, 0, 32'd900));

        // randomized traffic over four flows, some near the wrap point
        rdy_mode = 1;
        for (int i = 0; i < 4; i++)
            do_init(FW'(10 + i), (i % 2 == 0) ? 32'hFFFF_FFC0 + SW'($urandom_range(0, 63)) : SW'($urandom));
        for (int i = 0; i < 300; i++) begin
            f = FW'(10 + $urandom_range(0, 3));
            cur = m_ack[f];
            s = cur + SW'($urandom_range(0, 60));
            case ($urandom_range(0, 3))
                0: a = cur;
                1: a = cur + SW'($urandom_range(1, 70));
                2: a = cur - SW'($urandom_range(1, 20));
                default: a = SW'($urandom);
            endcase
            if ($urandom_range(0, 24) == 0)
                do_init(f, SW'($urandom));
            do_req(f, a, s);
        end
        drain();
        rdy_mode = 0;

`ifdef ACK_TRACK_STATS_EN
        check("stat_new", stat_new_ack, sc_new);
        check("stat_dup", stat_dup_ack, sc_dup);
        check("stat_rt", stat_rt, sc_rt);
        check("stat_stale", stat_stale, sc_stale);
`endif

        // asynchronous reset with a response pending
        rdy_mode = 3;
        @(posedge clk); #1;
        do_req(1, 32'd250, 32'd300);
        do_req(2, 32'd6000, 32'd7000);
        for (int i = 0; i < 20 && !resp_val; i++) @(negedge clk);
        check("pre_rst_val", resp_val, 1'b1);
        #2;
        rst = 1;
        #1;
        check("async_rst_val", resp_val, 1'b0);
        check("async_rst_rdys", {init_rdy, req_rdy}, 2'b11);
`ifdef ACK_TRACK_STATS_EN
        check("rst_stats", {stat_new_ack, stat_dup_ack, stat_rt, stat_stale}, '0);
`endif
        exp_q.delete();
        @(posedge clk); #1;
        rst = 0;
        rdy_mode = 0;
        repeat (3) @(negedge clk);
        check("post_rst_val", resp_val, 1'b0);
        check("post_rst_q", exp_q.size(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
